// File: rtl/rwkv_crg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rwkv_crg_pkg
// Description : Shared types and constants for the rwkv clock/reset
//               generator bring-up sequencer: FSM state encoding, domain
//               indices into dom_rst_n, and the domain release order.
// Revision    : 1.0 - initial release
// ============================================================================
package rwkv_crg_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_REL       = 3'd2,
        ST_RUN       = 3'd3,
        ST_SW_HOLD   = 3'd4,
        ST_SW_SETTLE = 3'd5
    } crg_state_e;

    // Bit positions inside dom_rst_n
    localparam int unsigned DOM_CLK1 = 0;
    localparam int unsigned DOM_CLK2 = 1;
    localparam int unsigned DOM_CLK3 = 2;
    localparam int unsigned N_DOM    = 3;

    // Domains are released clk2 first, then clk3, and clk1 last
    localparam logic [1:0] REL_ORDER [N_DOM] = '{2'd1, 2'd2, 2'd0};

    // Maps a release index to a dom_rst_n bit position
    function automatic logic [1:0] rel_dom(input logic [1:0] idx);
        case (idx)
            2'd0:    rel_dom = REL_ORDER[0];
            2'd1:    rel_dom = REL_ORDER[1];
            default: rel_dom = REL_ORDER[2];
        endcase
    endfunction

endpackage : rwkv_crg_pkg
`default_nettype wire

// File: rtl/rwkv_sync2.sv
`default_nettype none
// ============================================================================
// Module      : rwkv_sync2
// Description : Two-flop synchroniser for a single asynchronous level.
//               Output resets to 0.
// Ports       : clk   - destination clock
//               rst_n - asynchronous active-low reset
//               d     - asynchronous input level
//               q     - synchronised level (2-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module rwkv_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule : rwkv_sync2
`default_nettype wire

// File: rtl/rwkv_crg_seq.sv
`default_nettype none
// ============================================================================
// Module      : rwkv_crg_seq
// Description : Bring-up and clk1 clock-switch sequencer feeding the rwkv
//               CRG. Holds the PLL in reset, waits for a stable lock,
//               releases the clk2, clk3 and clk1 domain resets in turn and
//               then performs glitch-safe clk1 source switches with clk1 held
//               in reset around the BUFGMUX select change. Any lock loss
//               after bring-up starts drops all domains and restarts.
// Ports       : clk_src       - free-running source clock (only clock)
//               rst_n_sys     - asynchronous active-low reset
//               pll_locked    - asynchronous PLL lock indication
//               sel_req       - requested clk1 source (clk_src domain level)
//               pll_reset     - PLL reset, active high
//               dom_rst_n     - per-domain reset request, active low
//                               [0]=clk1 [1]=clk2 [2]=clk3
//               clk1_sel      - BUFGMUX select for clk1
//               busy          - high whenever the sequencer is not in RUN
//               lock_lost_cnt - saturating count of lock losses after bring-up
//               lock_timeout  - one-cycle pulse per WAIT_LOCK timeout
//                               (only with RWKV_CRG_LOCK_TIMEOUT_EN)
// Options     : RWKV_CRG_LOCK_TIMEOUT_EN - bound WAIT_LOCK by
//               LOCK_TIMEOUT_CYC total cycles and retry the PLL reset.
// Revision    : 1.0 - initial release
// ============================================================================
module rwkv_crg_seq
    import rwkv_crg_pkg::*;
#(
    parameter int unsigned PLL_RST_CYC     = 64,
    parameter int unsigned LOCK_STABLE_CYC = 256,
    parameter int unsigned REL_GAP_CYC     = 16,
    parameter int unsigned SW_HOLD_CYC     = 8,
    parameter int unsigned SW_SETTLE_CYC   = 32,
`ifdef RWKV_CRG_LOCK_TIMEOUT_EN
    parameter int unsigned LOCK_TIMEOUT_CYC = 65535,
`endif
    parameter int unsigned CNT_W           = 16,
    parameter logic        SEL_INIT        = 1'b0
) (
    input  logic       clk_src,
    input  logic       rst_n_sys,
    input  logic       pll_locked,
    input  logic       sel_req,
    output logic       pll_reset,
    output logic [2:0] dom_rst_n,
    output logic       clk1_sel,
    output logic       busy,
    output logic [7:0] lock_lost_cnt
`ifdef RWKV_CRG_LOCK_TIMEOUT_EN
    ,
    output logic       lock_timeout
`endif
);

    localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_PLL_END    = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] c_STABLE_END = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] c_GAP_END    = CNT_W'(REL_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] c_HOLD_END   = CNT_W'(SW_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] c_SETTLE_END = CNT_W'(SW_SETTLE_CYC - 1);
`ifdef RWKV_CRG_LOCK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_TO_END     = CNT_W'(LOCK_TIMEOUT_CYC - 1);
`endif

    logic lk;

    crg_state_e       state_q,     state_d;
    logic [CNT_W-1:0] timer_q,     timer_d;
    logic [1:0]       rel_idx_q,   rel_idx_d;
    logic             pll_reset_q, pll_reset_d;
    logic [2:0]       dom_rst_n_q, dom_rst_n_d;
    logic             clk1_sel_q,  clk1_sel_d;
    logic             busy_q,      busy_d;
    logic [7:0]       lost_cnt_q,  lost_cnt_d;
`ifdef RWKV_CRG_LOCK_TIMEOUT_EN
    logic [CNT_W-1:0] to_cnt_q,    to_cnt_d;
    logic             lock_to_q,   lock_to_d;
`endif

    logic lock_loss;
    logic count_loss;

    rwkv_sync2 u_lock_sync (
        .clk   (clk_src),
        .rst_n (rst_n_sys),
        .d     (pll_locked),
        .q     (lk)
    );

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + c_ONE;
        rel_idx_d   = rel_idx_q;
        pll_reset_d = pll_reset_q;
        dom_rst_n_d = dom_rst_n_q;
        clk1_sel_d  = clk1_sel_q;
        lost_cnt_d  = lost_cnt_q;
        lock_loss   = 1'b0;
        count_loss  = 1'b0;
`ifdef RWKV_CRG_LOCK_TIMEOUT_EN
        // Zero outside WAIT_LOCK, so it starts cleared on every entry
        to_cnt_d    = '0;
        lock_to_d   = 1'b0;
`endif

        case (state_q)
            ST_PLL_RST: begin
                pll_reset_d = 1'b1;
                dom_rst_n_d = '0;
                if (timer_q == c_PLL_END) begin
                    state_d     = ST_WAIT_LOCK;
                    timer_d     = '0;
                    pll_reset_d = 1'b0;
                end
            end

            ST_WAIT_LOCK: begin
`ifdef RWKV_CRG_LOCK_TIMEOUT_EN
                to_cnt_d = to_cnt_q + c_ONE;
`endif
                // timer counts consecutive synced-locked cycles
                if (lk && (timer_q == c_STABLE_END)) begin
                    state_d                  = ST_REL;
                    timer_d                  = '0;
                    rel_idx_d                = 2'd1;
                    dom_rst_n_d[rel_dom(2'd0)] = 1'b1;
                end
`ifdef RWKV_CRG_LOCK_TIMEOUT_EN
                else if (to_cnt_q == c_TO_END) begin
                    state_d     = ST_PLL_RST;
                    timer_d     = '0;
                    pll_reset_d = 1'b1;
                    lock_to_d   = 1'b1;
                end
`endif
                else if (!lk) begin
                    timer_d = '0;
                end
            end

            ST_REL: begin
                if (!lk) begin
                    lock_loss = 1'b1;
                end else if (timer_q == c_GAP_END) begin
                    timer_d = '0;
                    if (rel_idx_q == 2'd3) begin
                        state_d = ST_RUN;
                    end else begin
                        dom_rst_n_d[rel_dom(rel_idx_q)] = 1'b1;
                        rel_idx_d                       = rel_idx_q + 2'd1;
                    end
                end
            end

            ST_RUN: begin
                timer_d = '0;
                if (!lk) begin
                    lock_loss  = 1'b1;
                    count_loss = 1'b1;
                end else if (sel_req != clk1_sel_q) begin
                    state_d               = ST_SW_HOLD;
                    dom_rst_n_d[DOM_CLK1] = 1'b0;
                end
            end

            ST_SW_HOLD: begin
                if (!lk) begin
                    lock_loss  = 1'b1;
                    count_loss = 1'b1;
                end else if (timer_q == c_HOLD_END) begin
                    state_d    = ST_SW_SETTLE;
                    timer_d    = '0;
                    clk1_sel_d = ~clk1_sel_q;
                end
            end

            ST_SW_SETTLE: begin
                if (!lk) begin
                    lock_loss  = 1'b1;
                    count_loss = 1'b1;
                end else if (timer_q == c_SETTLE_END) begin
                    state_d               = ST_RUN;
                    timer_d               = '0;
                    dom_rst_n_d[DOM_CLK1] = 1'b1;
                end
            end

            default: begin
                state_d = ST_PLL_RST;
                timer_d = '0;
            end
        endcase

        // Lock loss overrides everything above in the same cycle;
        // clk1_sel is intentionally left untouched.
        if (lock_loss) begin
            state_d     = ST_PLL_RST;
            timer_d     = '0;
            pll_reset_d = 1'b1;
            dom_rst_n_d = '0;
        end

        if (count_loss && (lost_cnt_q != 8'hFF)) begin
            lost_cnt_d = lost_cnt_q + 8'd1;
        end

        busy_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk_src or negedge rst_n_sys) begin
        if (!rst_n_sys) begin
            state_q     <= ST_PLL_RST;
            timer_q     <= '0;
            rel_idx_q   <= 2'd0;
            pll_reset_q <= 1'b1;
            dom_rst_n_q <= 3'b000;
            clk1_sel_q  <= SEL_INIT;
            busy_q      <= 1'b1;
            lost_cnt_q  <= 8'd0;
`ifdef RWKV_CRG_LOCK_TIMEOUT_EN
            to_cnt_q    <= '0;
            lock_to_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            rel_idx_q   <= rel_idx_d;
            pll_reset_q <= pll_reset_d;
            dom_rst_n_q <= dom_rst_n_d;
            clk1_sel_q  <= clk1_sel_d;
            busy_q      <= busy_d;
            lost_cnt_q  <= lost_cnt_d;
`ifdef RWKV_CRG_LOCK_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            lock_to_q   <= lock_to_d;
`endif
        end
    end

    assign pll_reset     = pll_reset_q;
    assign dom_rst_n     = dom_rst_n_q;
    assign clk1_sel      = clk1_sel_q;
    assign busy          = busy_q;
    assign lock_lost_cnt = lost_cnt_q;
`ifdef RWKV_CRG_LOCK_TIMEOUT_EN
    assign lock_timeout  = lock_to_q;
`endif

endmodule : rwkv_crg_seq
`default_nettype wire
